reg_serial_tx_6_bit: RTL and testbench
======================================

# reg_serial_tx_6_bit

Serial transmitter that reads a 6-bit register's parallel output and shifts it out on a single wire as a framed, LSB-first bit stream. It gives the 6-bit CPU a way to export register contents, such as debug readback or an output port, to an external receiver. It captures one word per valid/ready handshake, holds it internally, and transmits it at a fixed clocks-per-bit rate.

## Interface
- CLKS_PER_BIT, 4: clock cycles per transmitted bit; legal range 1..64; the bit timer is $clog2(CLKS_PER_BIT)+1 bits wide.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- d_in  input  6  parallel word, normally driven by a 6-bit register's d_out.
- load  input  1  word-valid; a word is accepted on a rising edge where load && ready.
- ready  output  1  high only in IDLE with rst low; the block can accept a word.
- busy  output  1  high in any state other than IDLE.
- tx  output  1  registered serial line; idles high.
- done  output  1  registered one-cycle pulse when the stop bit completes.

## Operation
- Frame: start bit (0), d[0]..d[5] LSB-first, optional parity bit (see Configuration), stop bit (1).
- States:
  - IDLE: tx=1. On load&&ready, capture d_in into a shift register, clear the bit timer and bit index, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0]. Each bit lasts CLKS_PER_BIT cycles. After 6 bits, go to PARITY when it is compiled in, otherwise STOP.
  - PARITY: tx=parity bit for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On its last cycle, go to IDLE and set done=1 for exactly one cycle.
- The bit timer counts 0..CLKS_PER_BIT-1. It advances state or bit on the cycle where timer==CLKS_PER_BIT-1 and wraps to 0.
- The word is captured at acceptance. Changes to d_in during a frame have no effect.
- load while busy is ignored. There is no queuing and no error flag.
- The last data bit index is 5. The index never wraps into a seventh bit.
- Reset values: tx=1, busy=0, done=0, state IDLE, shift register 0, timer 0, index 0. ready=0 while rst is high and 1 on the first cycle after rst deasserts.
- Reset mid-frame aborts the frame:
  - tx=1 at the next edge.
  - No done pulse.
  - The partial frame is not resumed.
- Load and reset together: reset wins and no word is captured.

## Timing
- Acceptance at edge k: tx=0, busy=1, ready=0 are visible after edge k.
- Frame length: F*CLKS_PER_BIT cycles, with F=8 without parity and F=9 with parity.
- done is high for the single cycle after the stop bit's last edge. ready=1 in that same cycle.
- Back-to-back transfers: with load held high, the next word is accepted at the edge ending the done cycle. This gives exactly one IDLE cycle (tx=1) between frames.
- CLKS_PER_BIT=1: one cycle per bit. All of the rules above still hold.

## Configuration
- REG_TX_PARITY_EN defined: a PARITY state is inserted after d[5]. tx carries even parity, the XOR of the 6 captured bits, so the total count of ones in data plus parity is even. The frame is 9 bits.
- REG_TX_PARITY_EN undefined: there is no PARITY state and no parity logic. DATA goes directly to STOP. The frame is 8 bits.

## Test plan
- Reset: hold rst for 3 cycles, with load=1 during reset → tx=1, busy=0, done=0, ready=0 during reset. ready=1 on the first cycle after reset. No frame starts from the load pulsed during reset.
- Basic frame, CLKS_PER_BIT=4, no parity: load d_in=6'b101101 → tx holds 0,1,0,1,1,0,1,1, each for 4 cycles (32 cycles total). done pulses once right after. busy=1 throughout.
- Parity on, CLKS_PER_BIT=4:
  - d_in=6'b101101 → parity bit 0.
  - d_in=6'b000001 → parity bit 1.
  - Both frames are 36 cycles.
- Back-to-back with load held high: 6'b111111 then 6'b000000 → exactly one IDLE cycle (tx=1) between the two stop bits and the second start bit. Changing d_in mid-frame does not alter the bits being sent.
- Load while busy: pulse load with 6'b010101 in the middle of the frame for 6'b000111 → the transmitted frame is unchanged and the pulsed word is never sent.
- Reset mid-frame: assert rst during bit d[2] → tx=1 and busy=0 after the edge, with no done pulse. A new load after reset produces a clean, full frame.

Source files
------------

// File: rtl/reg_serial_tx_6_bit.sv
// Framed LSB-first serial transmitter for a 6-bit register word (start, d[0..5], [parity], stop).
// Define REG_TX_PARITY_EN to insert an even-parity bit after d[5].
module reg_serial_tx_6_bit #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] d_in,
  input  logic       load,
  output logic       ready,
  output logic       busy,
  output logic       tx,
  output logic       done
);

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

`ifdef REG_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        state;
  logic [5:0]    shift;
  logic [TW-1:0] timer;
  logic [2:0]    idx;
  logic          timer_last;

`ifdef REG_TX_PARITY_EN
  logic          par;
`endif

  assign timer_last = (timer == TIMER_LAST);
  assign busy       = (state != S_IDLE);
  // ready is gated by rst directly so it drops in the same cycle reset is asserted.
  assign ready      = (state == S_IDLE) && !rst;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      shift <= '0;
      timer <= '0;
      idx   <= '0;
      tx    <= 1'b1;
      done  <= 1'b0;
`ifdef REG_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (load) begin
            shift <= d_in;
            timer <= '0;
            idx   <= '0;
            tx    <= 1'b0;
            state <= S_START;
`ifdef REG_TX_PARITY_EN
            par   <= ^d_in;
`endif
          end
        end

        S_START: begin
          if (timer_last) begin
            timer <= '0;
            tx    <= shift[0];
            state <= S_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_DATA: begin
          if (timer_last) begin
            timer <= '0;
            if (idx == 3'd5) begin
`ifdef REG_TX_PARITY_EN
              tx    <= par;
              state <= S_PARITY;
`else
              tx    <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              // Present the next bit in the same edge the shifter advances.
              idx   <= idx + 1'b1;
              shift <= {1'b0, shift[5:1]};
              tx    <= shift[1];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

`ifdef REG_TX_PARITY_EN
        S_PARITY: begin
          if (timer_last) begin
            timer <= '0;
            tx    <= 1'b1;
            state <= S_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif

        S_STOP: begin
          tx <= 1'b1;
          if (timer_last) begin
            timer <= '0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          tx    <= 1'b1;
          timer <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_serial_tx_6_bit.sv
// Scoreboard bench for reg_serial_tx_6_bit: stimulus queues expected words, a monitor checks each frame.
module tb_reg_serial_tx_6_bit;

  localparam int CPB = 4;
`ifdef REG_TX_PARITY_EN
  localparam int F = 9;
`else
  localparam int F = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] d_in = 6'b101010;
  logic       load = 1'b1;
  logic       ready, busy, tx, done;

  typedef struct {
    logic [5:0] w;
    bit         abort;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_sent = 0;
  int   done_count = 0;

  reg_serial_tx_6_bit #(.CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .rst  (rst),
    .d_in (d_in),
    .load (load),
    .ready(ready),
    .busy (busy),
    .tx   (tx),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Expected line level per bit slot: start, d[0..5], [even parity], stop.
  function automatic logic [8:0] frame_bits(input logic [5:0] w);
    logic [8:0] f;
    f      = 9'h1ff;
    f[0]   = 1'b0;
    f[6:1] = w;
`ifdef REG_TX_PARITY_EN
    f[7]   = ^w;
`endif
    return f;
  endfunction

  always @(negedge clk) if (done === 1'b1) done_count++;

  // Monitor: detects each frame start and compares it against the oldest queued word.
  initial begin : monitor
    exp_t       e;
    logic [8:0] fb;
    int         bad;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && rst === 1'b0) begin
        if (sb.size() == 0) begin
          timeout_fail("unexpected_frame");
          for (int i = 0; i < 2 * F * CPB && busy === 1'b1; i++) @(negedge clk);
        end else begin
          e = sb.pop_front();
          fb = frame_bits(e.w);
          bad = 0;
          aborted = 0;
          for (int c = 0; c < F * CPB; c++) begin
            if (c > 0) @(negedge clk);
            if (rst === 1'b1) begin
              aborted = 1;
              break;
            end
            if (tx !== fb[c / CPB] || busy !== 1'b1 || done !== 1'b0) bad++;
            if (c % CPB == CPB - 1) begin
              check($sformatf("w%b_slot%0d_bad_cycles", e.w, c / CPB), bad, 0);
              bad = 0;
            end
          end
          if (aborted) begin
            check($sformatf("w%b_abort_expected", e.w), 1, {31'd0, e.abort});
            @(negedge clk);
            check($sformatf("w%b_after_abort_tx_busy_done", e.w), {tx, busy, done}, 3'b100);
          end else begin
            check($sformatf("w%b_completed_not_aborted", e.w), {31'd0, e.abort}, 0);
            @(negedge clk);
            check($sformatf("w%b_done_ready_tx", e.w), {done, ready, tx}, 3'b111);
          end
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int i;
    for (i = 0; i < 4 * F * CPB; i++) begin
      @(negedge clk);
      if (ready === 1'b1) break;
    end
    if (i == 4 * F * CPB) timeout_fail(name);
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 4 * F * CPB; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    if (i == 4 * F * CPB) timeout_fail(name);
  endtask

  // Offers a word once ready; d_in is scrambled right after acceptance to prove capture.
  task automatic send(input logic [5:0] w, input bit abort);
    exp_t e;
    wait_ready($sformatf("ready_before_w%b", w));
    e.w = w;
    e.abort = abort;
    sb.push_back(e);
    if (!abort) n_sent++;
    d_in = w;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    d_in = ~w;
  endtask

  initial begin : stimulus
    exp_t e;
    // Reset held 3 cycles with load asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_cycle%0d_tx_busy_done_ready", i), {tx, busy, done, ready}, 4'b1000);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    load = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {ready, busy, tx}, 3'b101);
    repeat (4) @(negedge clk);
    check("no_frame_from_reset_load", {busy, tx}, 2'b01);

    send(6'b101101, 0);
    send(6'b000001, 0);

    // Back-to-back with load held high; d_in switches to the second word mid-frame.
    wait_ready("ready_before_b2b");
    e.abort = 0;
    e.w = 6'b111111;
    sb.push_back(e);
    e.w = 6'b000000;
    sb.push_back(e);
    n_sent += 2;
    d_in = 6'b111111;
    load = 1'b1;
    @(posedge clk);
    #1;
    d_in = 6'b000000;
    wait_done("b2b_first_done");
    @(posedge clk);
    #1;
    load = 1'b0;
    @(negedge clk);
    check("b2b_restart_busy_tx", {busy, tx}, 2'b10);

    // Load pulsed while busy must be ignored.
    send(6'b000111, 0);
    repeat (10) @(posedge clk);
    #1;
    d_in = 6'b010101;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    check("load_while_busy_ready_low", {ready, busy}, 2'b01);

    // Reset during d[2] aborts the frame.
    send(6'b110010, 1);
    repeat (3 * CPB + 1) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(6'b100110, 0);

    wait_ready("final_idle");
    repeat (F * CPB) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("done_pulse_count", done_count, n_sent);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
